// File: rtl/seg_scan_mux_pkg.sv
// Shared types and constants for the 8-digit 7-segment scan multiplexer.
package seg_scan_mux_pkg;

    // Scan FSM states
    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned NIB_W      = 4;

    // Display dark: all segments and anodes are active-low
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Hex nibble -> active-low gfedcba
    localparam logic [6:0] HEX7_TAB [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg_scan_mux_hex7.sv
// Nibble + decimal point + blank -> active-low segment pattern (combinational).
//  nib    in  4  hex value to display
//  dp     in  1  1 = decimal point lit
//  blank  in  1  1 = all of a..g dark (dp unaffected)
//  seg_c  out 8  {dp, g..a}, active-low
module seg_hex7
    import seg_scan_mux_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg_c
);

    always_comb begin
        seg_c = {~dp, (blank ? 7'h7F : HEX7_TAB[nib])};
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes eight snapshotted hex digits onto a common-anode 7-segment display.
//  clk         system clock
//  rst         synchronous reset, active-high
//  din         eight nibbles, din[3:0] = rightmost digit (an[0])
//  dp_in       decimal point per digit, 1 = lit
//  lz_en       1 = suppress leading zeros
//  an          anode enables, active-low, one-cold or all high
//  seg         {dp, g..a}, active-low
//  cur_digit   digit index occupying the current slot
//  frame_done  one-cycle pulse in the S_LOAD cycle after a completed frame
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int unsigned SHOW_CYC  = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic [7:0]  dp_in,
    input  logic        lz_en,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [2:0]  cur_digit,
    output logic        frame_done
);

    localparam int unsigned MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        snap_din;
    logic [7:0]         snap_dp;
    logic               snap_lz;

    logic [31:0]        src_din;
    logic [7:0]         src_dp;
    logic               src_lz;
    logic [7:0]         lz_mask;
    logic [2:0]         nxt_digit;
    logic [7:0]         dec_seg;
    logic [7:0]         dec_an;

    // In S_LOAD the snapshot is being written this edge, so decode from live inputs
    always_comb begin
        src_din = (state == S_LOAD) ? din   : snap_din;
        src_dp  = (state == S_LOAD) ? dp_in : snap_dp;
        src_lz  = (state == S_LOAD) ? lz_en : snap_lz;
    end

    // Digit that will occupy the slot after this edge
    always_comb begin
        nxt_digit = cur_digit;
        case (state)
            S_LOAD:  nxt_digit = 3'd0;
            S_SHOW:  nxt_digit = (cur_digit == 3'd7) ? 3'd0 : cur_digit + 3'd1;
            default: nxt_digit = cur_digit;
        endcase
    end

    // Leading-zero mask: a digit is blank when it and every digit above it is zero
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero & (src_din[i*NIB_W +: NIB_W] == 4'h0);
            lz_mask[i] = src_lz & all_zero;
        end
    end

    always_comb begin
        dec_an = ~(8'b1 << nxt_digit);
    end

    seg_hex7 u_hex7 (
        .nib   (src_din[{nxt_digit, 2'b00} +: 4]),
        .dp    (src_dp[nxt_digit]),
        .blank (lz_mask[nxt_digit]),
        .seg_c (dec_seg)
    );

    // Scan FSM; an/seg take the value of the state entered on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LOAD;
            cnt        <= '0;
            cur_digit  <= 3'd0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
            snap_din   <= '0;
            snap_dp    <= '0;
            snap_lz    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_LOAD: begin
                    snap_din  <= din;
                    snap_dp   <= dp_in;
                    snap_lz   <= lz_en;
                    cnt       <= '0;
                    cur_digit <= 3'd0;
                    if (BLANK_CYC > 0) begin
                        state <= S_BLANK;
                        an    <= AN_OFF;
                        seg   <= SEG_OFF;
                    end else begin
                        state <= S_SHOW;
                        an    <= dec_an;
                        seg   <= dec_seg;
                    end
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= S_SHOW;
                        cnt   <= '0;
                        an    <= dec_an;
                        seg   <= dec_seg;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt <= '0;
                        if (cur_digit == 3'd7) begin
                            state      <= S_LOAD;
                            cur_digit  <= 3'd0;
                            an         <= AN_OFF;
                            seg        <= SEG_OFF;
                            frame_done <= 1'b1;
                        end else begin
                            cur_digit <= nxt_digit;
                            if (BLANK_CYC > 0) begin
                                state <= S_BLANK;
                                an    <= AN_OFF;
                                seg   <= SEG_OFF;
                            end else begin
                                state <= S_SHOW;
                                an    <= dec_an;
                                seg   <= dec_seg;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_LOAD;
                    cnt   <= '0;
                    an    <= AN_OFF;
                    seg   <= SEG_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: one instance with a blank phase, one without.
module tb_seg_scan_mux;

    logic        clk;
    logic        rst;
    logic        rst0;
    logic [31:0] din;
    logic [7:0]  dp_in;
    logic        lz_en;

    logic [7:0]  an,  seg;
    logic [2:0]  cur_digit;
    logic        frame_done;
    logic [7:0]  an0, seg0;
    logic [2:0]  cur_digit0;
    logic        frame_done0;

    int checks = 0;
    int errors = 0;

    logic [6:0] enc [16];

    seg_scan_mux #(.SHOW_CYC(4), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .cur_digit  (cur_digit),
        .frame_done (frame_done)
    );

    seg_scan_mux #(.SHOW_CYC(4), .BLANK_CYC(0)) dut0 (
        .clk        (clk),
        .rst        (rst0),
        .din        (din),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .an         (an0),
        .seg        (seg0),
        .cur_digit  (cur_digit0),
        .frame_done (frame_done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compare all four outputs of the selected instance
    task automatic chk_out(input bit sel, input string tag, input logic [7:0] e_an,
                           input logic [7:0] e_seg, input logic [2:0] e_cd, input logic e_fd);
        logic [7:0] o_an, o_seg;
        logic [2:0] o_cd;
        logic       o_fd;
        o_an  = sel ? an0 : an;
        o_seg = sel ? seg0 : seg;
        o_cd  = sel ? cur_digit0 : cur_digit;
        o_fd  = sel ? frame_done0 : frame_done;
        chk({tag, " an"},  32'(o_an),  32'(e_an));
        chk({tag, " seg"}, 32'(o_seg), 32'(e_seg));
        chk({tag, " cd"},  32'(o_cd),  32'(e_cd));
        chk({tag, " fd"},  32'(o_fd),  32'(e_fd));
    endtask

    // Walk one frame starting in the first cycle after the S_LOAD exit edge; ends in
    // the following S_LOAD cycle without advancing. din switches to nd at the start
    // of digit index chg's show phase.
    task automatic run_frame(input bit sel, input int b, input logic [31:0] d,
                             input logic [7:0] dp, input bit lz, input int chg,
                             input logic [31:0] nd);
        logic [7:0] bl;
        bit         allz;
        logic [3:0] nib;
        logic [6:0] e;
        allz = 1'b1;
        bl   = '0;
        for (int k = 7; k >= 1; k--) begin
            allz  = allz && (d[4*k +: 4] == 4'h0);
            bl[k] = lz && allz;
        end
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < b; i++) begin
                chk_out(sel, $sformatf("blank d%0d c%0d", k, i), 8'hFF, 8'hFF, 3'(k), 1'b0);
                tick();
            end
            for (int i = 0; i < 4; i++) begin
                if (k == chg && i == 0) din = nd;
                nib = d[4*k +: 4];
                e   = bl[k] ? 7'h7F : enc[nib];
                chk_out(sel, $sformatf("show d%0d c%0d", k, i), ~(8'b1 << k), {~dp[k], e},
                        3'(k), 1'b0);
                tick();
            end
        end
        chk_out(sel, "load", 8'hFF, 8'hFF, 3'd0, 1'b1);
    endtask

    initial begin
        enc = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst   = 1'b1;
        rst0  = 1'b1;
        din   = 32'h0;
        dp_in = 8'h00;
        lz_en = 1'b0;
        tick();
        tick();
        chk_out(0, "reset", 8'hFF, 8'hFF, 3'd0, 1'b0);

        // Plain scan of 87654321; first S_LOAD has no frame_done
        din = 32'h87654321;
        rst = 1'b0;
        chk_out(0, "first load", 8'hFF, 8'hFF, 3'd0, 1'b0);
        tick();
        run_frame(0, 2, 32'h87654321, 8'h00, 1'b0, -1, 32'h0);

        // Leading-zero suppression
        din   = 32'h00000A05;
        lz_en = 1'b1;
        tick();
        run_frame(0, 2, 32'h00000A05, 8'h00, 1'b1, -1, 32'h0);
        din = 32'h0;
        tick();
        run_frame(0, 2, 32'h00000000, 8'h00, 1'b1, -1, 32'h0);

        // Input change mid-frame is held off until the next snapshot
        din   = 32'h87654321;
        lz_en = 1'b0;
        tick();
        run_frame(0, 2, 32'h87654321, 8'h00, 1'b0, 2, 32'h12345678);
        tick();
        run_frame(0, 2, 32'h12345678, 8'h00, 1'b0, -1, 32'h0);

        // Decimal point on digit 3 only
        dp_in = 8'h04;
        tick();
        run_frame(0, 2, 32'h12345678, 8'h04, 1'b0, -1, 32'h0);

        // Reset during digit 5 show aborts the frame
        dp_in = 8'h00;
        din   = 32'h87654321;
        tick();
        repeat (27) tick();
        chk_out(0, "pre-abort", 8'hEF, {1'b1, enc[5]}, 3'd4, 1'b0);
        rst = 1'b1;
        tick();
        chk_out(0, "abort", 8'hFF, 8'hFF, 3'd0, 1'b0);
        rst = 1'b0;
        tick();
        run_frame(0, 2, 32'h87654321, 8'h00, 1'b0, -1, 32'h0);

        // No blank phase: 33-clock frame
        rst0 = 1'b0;
        chk_out(1, "nb first load", 8'hFF, 8'hFF, 3'd0, 1'b0);
        tick();
        run_frame(1, 0, 32'h87654321, 8'h00, 1'b0, -1, 32'h0);
        din   = 32'h00000A05;
        lz_en = 1'b1;
        dp_in = 8'h81;
        tick();
        run_frame(1, 0, 32'h00000A05, 8'h81, 1'b1, -1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
